// File: rtl/xor_parity_serializer_pkg.sv
// Shared definitions for the XOR parity serializer and its matching checker:
// FSM state encodings, the default frame width and the parity-sense constants.
package xor_parity_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 8;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/xor_parity_serializer_parity_accum.sv
// One-bit running XOR accumulator for the serializer's trailing parity bit.
// clear has priority over load, load over enable; the parity output applies
// the odd-parity inversion so the caller never has to.
module parity_accum
    import xor_parity_serializer_pkg::*;
#(
    parameter bit ODD_PARITY = PARITY_EVEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic load_bit,
    input  logic en,
    input  logic bit_in,
    output logic parity
);

    logic acc;

    // Accumulate XOR of every data bit of the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clear) begin
            acc <= 1'b0;
        end else if (load) begin
            acc <= load_bit;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

    assign parity = acc ^ ODD_PARITY;

endmodule

// File: rtl/xor_parity_serializer.sv
// Parallel-to-serial frame stage: accepts a DATA_W-bit word on a valid/ready
// handshake, emits it LSB-first one bit per transfer, then appends a single
// parity bit flagged with ser_last. Back-to-back frames have no idle bubble.
module xor_parity_serializer
    import xor_parity_serializer_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit ODD_PARITY = PARITY_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ser_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              parity;

    logic xfer;
    logic accept;
    logic last_bit;
    logic acc_clear;
    logic acc_en;

    assign xfer     = ser_valid && ser_ready;
    assign accept   = in_valid && in_ready;
    assign last_bit = (bit_cnt == LAST_CNT);

    // The frame ends with no follow-on word: drop the accumulator back to zero.
    assign acc_clear = (state == ST_PARITY) && xfer && !in_valid;
    // Fold in the bit that becomes current after this transfer; the last data
    // bit is already included by the time it is on the wire.
    assign acc_en    = (state == ST_SHIFT) && xfer && !last_bit;

    parity_accum #(
        .ODD_PARITY(ODD_PARITY)
    ) u_parity_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (acc_clear),
        .load    (accept),
        .load_bit(in_data[0]),
        .en      (acc_en),
        .bit_in  (shift_reg[1]),
        .parity  (parity)
    );

    // Ready is open in IDLE, and in PARITY only when the parity bit leaves now.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_IDLE:   in_ready = 1'b1;
            ST_PARITY: in_ready = ser_ready;
            default:   in_ready = 1'b0;
        endcase
    end

    // Frame FSM with shift register, bit counter and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state     <= ST_SHIFT;
                        shift_reg <= in_data;
                        bit_cnt   <= '0;
                        ser_out   <= in_data[0];
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (xfer) begin
                        if (last_bit) begin
                            state    <= ST_PARITY;
                            ser_out  <= parity;
                            ser_last <= 1'b1;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            ser_out   <= shift_reg[1];
                        end
                    end
                end

                ST_PARITY: begin
                    if (xfer) begin
                        if (in_valid) begin
                            // Next word starts immediately after the parity bit.
                            state     <= ST_SHIFT;
                            shift_reg <= in_data;
                            bit_cnt   <= '0;
                            ser_out   <= in_data[0];
                            ser_valid <= 1'b1;
                            ser_last  <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            ser_out   <= 1'b0;
                            ser_valid <= 1'b0;
                            ser_last  <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_parity_serializer.sv
// Directed bench for xor_parity_serializer: an 8-bit even build, an 8-bit odd
// build sharing its inputs, and a separate 2-bit even build.
module tb_xor_parity_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_ready;

    logic in_ready_e, ser_out_e, ser_valid_e, ser_last_e, busy_e;
    logic in_ready_o, ser_out_o, ser_valid_o, ser_last_o, busy_o;

    logic [1:0] d2_data;
    logic       d2_valid;
    logic       d2_ready;
    logic       in_ready_2, ser_out_2, ser_valid_2, ser_last_2, busy_2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xor_parity_serializer #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_e), .ser_ready(ser_ready), .ser_out(ser_out_e),
        .ser_valid(ser_valid_e), .ser_last(ser_last_e), .busy(busy_e)
    );

    xor_parity_serializer #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_o), .ser_ready(ser_ready), .ser_out(ser_out_o),
        .ser_valid(ser_valid_o), .ser_last(ser_last_o), .busy(busy_o)
    );

    xor_parity_serializer #(.DATA_W(2), .ODD_PARITY(1'b0)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2_data), .in_valid(d2_valid),
        .in_ready(in_ready_2), .ser_ready(d2_ready), .ser_out(ser_out_2),
        .ser_valid(ser_valid_2), .ser_last(ser_last_2), .busy(busy_2)
    );

    task automatic test_reset();
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; ser_ready = 1'b1;
        d2_data = 2'b00; d2_valid = 1'b0; d2_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_assert++; if (ser_valid_e !== 1'b0) begin n_fail++; $display("FAIL reset_ser_valid: got %b want 0", ser_valid_e); end
        n_assert++; if (ser_out_e !== 1'b0) begin n_fail++; $display("FAIL reset_ser_out: got %b want 0", ser_out_e); end
        n_assert++; if (ser_last_e !== 1'b0) begin n_fail++; $display("FAIL reset_ser_last: got %b want 0", ser_last_e); end
        n_assert++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_e); end
        n_assert++; if (ser_valid_2 !== 1'b0) begin n_fail++; $display("FAIL reset_w2_valid: got %b want 0", ser_valid_2); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_assert++; if (in_ready_e !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready_e); end
        n_assert++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy_e); end
    endtask

    task automatic test_even_a5();
        logic [8:0] exp;
        exp = 9'b0_1010_0101;
        in_data = 8'hA5; in_valid = 1'b1; ser_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'hxx;
        for (int i = 0; i < 9; i++) begin
            n_assert++; if (ser_valid_e !== 1'b1) begin n_fail++; $display("FAIL a5_valid%0d: got %b want 1", i, ser_valid_e); end
            n_assert++; if (ser_out_e !== exp[i]) begin n_fail++; $display("FAIL a5_bit%0d: got %b want %b", i, ser_out_e, exp[i]); end
            n_assert++; if (ser_last_e !== (i == 8)) begin n_fail++; $display("FAIL a5_last%0d: got %b want %b", i, ser_last_e, (i == 8)); end
            n_assert++; if (busy_e !== 1'b1) begin n_fail++; $display("FAIL a5_busy%0d: got %b want 1", i, busy_e); end
            @(posedge clk); #1;
        end
        n_assert++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL a5_busy_end: got %b want 0", busy_e); end
        n_assert++; if (ser_valid_e !== 1'b0) begin n_fail++; $display("FAIL a5_valid_end: got %b want 0", ser_valid_e); end
        n_assert++; if (ser_out_e !== 1'b0) begin n_fail++; $display("FAIL a5_out_end: got %b want 0", ser_out_e); end
        in_data = 8'h00;
    endtask

    task automatic test_parity_sense();
        logic [8:0] exp_e;
        logic [8:0] exp_o;
        exp_e = 9'b1_0000_0111;
        exp_o = 9'b0_0000_0111;
        in_data = 8'h07; in_valid = 1'b1; ser_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_assert++; if (ser_out_e !== exp_e[i]) begin n_fail++; $display("FAIL p07_even_bit%0d: got %b want %b", i, ser_out_e, exp_e[i]); end
            n_assert++; if (ser_out_o !== exp_o[i]) begin n_fail++; $display("FAIL p07_odd_bit%0d: got %b want %b", i, ser_out_o, exp_o[i]); end
            n_assert++; if (ser_last_o !== (i == 8)) begin n_fail++; $display("FAIL p07_odd_last%0d: got %b want %b", i, ser_last_o, (i == 8)); end
            @(posedge clk); #1;
        end
        n_assert++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL p07_odd_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] f1;
        logic [8:0] f2;
        logic       eb;
        logic       el;
        f1 = 9'b0_1111_1111;
        f2 = 9'b1_0000_0001;
        in_data = 8'hFF; in_valid = 1'b1; ser_ready = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h01;
        for (int i = 0; i < 18; i++) begin
            if (i == 9) in_valid = 1'b0;
            #1;
            eb = (i < 9) ? f1[i] : f2[i-9];
            el = (i == 8) || (i == 17);
            n_assert++; if (ser_valid_e !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %b want 1", i, ser_valid_e); end
            n_assert++; if (ser_out_e !== eb) begin n_fail++; $display("FAIL b2b_bit%0d: got %b want %b", i, ser_out_e, eb); end
            n_assert++; if (ser_last_e !== el) begin n_fail++; $display("FAIL b2b_last%0d: got %b want %b", i, ser_last_e, el); end
            n_assert++; if (in_ready_e !== el) begin n_fail++; $display("FAIL b2b_in_ready%0d: got %b want %b", i, in_ready_e, el); end
            @(posedge clk); #1;
        end
        n_assert++; if (ser_valid_e !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_end: got %b want 0", ser_valid_e); end
    endtask

    task automatic test_backpressure();
        logic [8:0] exp;
        logic [3:0] pat;
        int idx;
        int cyc;
        exp = 9'b0_0011_1100;
        pat = 4'b1001;
        in_data = 8'h3C; in_valid = 1'b1; ser_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 9 && cyc < 60) begin
            ser_ready = pat[cyc % 4];
            #1;
            n_assert++; if (ser_valid_e !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b want 1", cyc, ser_valid_e); end
            n_assert++; if (ser_out_e !== exp[idx]) begin n_fail++; $display("FAIL bp_bit%0d_c%0d: got %b want %b", idx, cyc, ser_out_e, exp[idx]); end
            n_assert++; if (ser_last_e !== (idx == 8)) begin n_fail++; $display("FAIL bp_last_c%0d: got %b want %b", cyc, ser_last_e, (idx == 8)); end
            n_assert++; if (in_ready_e !== ((idx == 8) && ser_ready)) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b want %b", cyc, in_ready_e, ((idx == 8) && ser_ready)); end
            if (ser_ready) idx++;
            cyc++;
            @(posedge clk); #1;
        end
        n_assert++; if (idx != 9) begin n_fail++; $display("FAIL bp_timeout: got %0d bits want 9", idx); end
        n_assert++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %b want 0", busy_e); end
        ser_ready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        logic [8:0] exp;
        exp = 9'b0_1000_0001;
        in_data = 8'hC3; in_valid = 1'b1; ser_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_assert++; if (ser_valid_e !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_valid: got %b want 1", ser_valid_e); end
        rst_n = 1'b0;
        #1;
        n_assert++; if (ser_valid_e !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", ser_valid_e); end
        n_assert++; if (ser_last_e !== 1'b0) begin n_fail++; $display("FAIL rst_mid_last: got %b want 0", ser_last_e); end
        n_assert++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy_e); end
        n_assert++; if (ser_out_e !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out: got %b want 0", ser_out_e); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_assert++; if (ser_last_e !== 1'b0) begin n_fail++; $display("FAIL rst_post_last: got %b want 0", ser_last_e); end
        n_assert++; if (in_ready_e !== 1'b1) begin n_fail++; $display("FAIL rst_post_in_ready: got %b want 1", in_ready_e); end
        in_data = 8'h81; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n_assert++; if (ser_out_e !== exp[i]) begin n_fail++; $display("FAIL r81_bit%0d: got %b want %b", i, ser_out_e, exp[i]); end
            n_assert++; if (ser_last_e !== (i == 8)) begin n_fail++; $display("FAIL r81_last%0d: got %b want %b", i, ser_last_e, (i == 8)); end
            @(posedge clk); #1;
        end
        n_assert++; if (ser_valid_e !== 1'b0) begin n_fail++; $display("FAIL r81_valid_end: got %b want 0", ser_valid_e); end
    endtask

    task automatic test_width2();
        logic [2:0] f1;
        logic [2:0] f2;
        logic       eb;
        logic       el;
        f1 = 3'b110;
        f2 = 3'b011;
        d2_data = 2'b10; d2_valid = 1'b1; d2_ready = 1'b1;
        @(posedge clk); #1;
        d2_data = 2'b11;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) d2_valid = 1'b0;
            #1;
            eb = (i < 3) ? f1[i] : f2[i-3];
            el = (i == 2) || (i == 5);
            n_assert++; if (ser_valid_2 !== 1'b1) begin n_fail++; $display("FAIL w2_valid%0d: got %b want 1", i, ser_valid_2); end
            n_assert++; if (ser_out_2 !== eb) begin n_fail++; $display("FAIL w2_bit%0d: got %b want %b", i, ser_out_2, eb); end
            n_assert++; if (ser_last_2 !== el) begin n_fail++; $display("FAIL w2_last%0d: got %b want %b", i, ser_last_2, el); end
            n_assert++; if (in_ready_2 !== el) begin n_fail++; $display("FAIL w2_in_ready%0d: got %b want %b", i, in_ready_2, el); end
            @(posedge clk); #1;
        end
        n_assert++; if (ser_valid_2 !== 1'b0) begin n_fail++; $display("FAIL w2_valid_end: got %b want 0", ser_valid_2); end
        n_assert++; if (busy_2 !== 1'b0) begin n_fail++; $display("FAIL w2_busy_end: got %b want 0", busy_2); end
    endtask

    initial begin
        test_reset();
        test_even_a5();
        test_parity_sense();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_width2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
